// File: rtl/ws2812_pixel_serializer_if.sv
// Pixel stream handshake between an upstream pixel source and the WS2812
// serializer.
//   pix_valid : source has a pixel word on pix_data/pix_last
//   pix_ready : serializer accepts the pixel on this rising edge
//   pix_data  : 24-bit GRB word, bit 23 is sent first
//   pix_last  : final pixel of the frame
// The master modport is the pixel source and the slave modport is the serializer.
interface ws2812_pixel_serializer_if;
  logic        pix_valid;
  logic        pix_ready;
  logic [23:0] pix_data;
  logic        pix_last;

  modport master (output pix_valid, output pix_data, output pix_last, input pix_ready);
  modport slave  (input pix_valid, input pix_data, input pix_last, output pix_ready);
endinterface

// File: rtl/ws2812_pixel_serializer.sv
// WS2812 pixel serializer. It accepts 24-bit pixel words over a valid/ready
// handshake and shifts them out MSB-first as three-phase WS2812 symbols.
// After the last pixel of a frame, or after an upstream underrun, it holds
// ws_data low for the latch interval.
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   pix        : pixel handshake (slave side of ws2812_pixel_serializer_if)
//   ws_data    : serial LED data, driven directly from a flop
//   ws_data_n  : complement of ws_data
//   busy       : high while shifting a pixel or running the latch interval
//   frame_done : one-cycle pulse in the first idle cycle after the latch
module ws2812_pixel_serializer #(
  parameter int T0H_CYC   = 1,
  parameter int T1H_CYC   = 2,
  parameter int BIT_CYC   = 3,
  parameter int RESET_CYC = 4000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  ws2812_pixel_serializer_if.slave     pix,
  output logic                         ws_data,
  output logic                         ws_data_n,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int CW = $clog2(BIT_CYC);
  localparam int LW = $clog2(RESET_CYC + 1);

  localparam logic [CW-1:0] CYC_LAST   = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] T0H_V      = CW'(T0H_CYC);
  localparam logic [CW-1:0] T1H_V      = CW'(T1H_CYC);
  localparam logic [LW-1:0] LATCH_LAST = LW'(RESET_CYC - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;

  if (!(T0H_CYC >= 1 && T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC && RESET_CYC >= 1)) begin : g_bad_params
    $error("ws2812_pixel_serializer: need 1 <= T0H_CYC < T1H_CYC < BIT_CYC and RESET_CYC >= 1");
  end

  logic [1:0]    state, state_d;
  logic [CW-1:0] cyc, cyc_d;
  logic [4:0]    bit_idx, bit_idx_d;
  logic [23:0]   shreg, shreg_d;
  logic          last_flag, last_flag_d;
  logic [LW-1:0] latch_cnt, latch_cnt_d;
  logic          frame_done_d;
  logic          ws_data_d;
  logic [CW-1:0] th_d;
  logic          armed;
  logic          pix_ready_int;
  logic          bit0_end;
  logic          xfer;

  assign bit0_end = (state == ST_SHIFT) && (cyc == CYC_LAST) && (bit_idx == 5'd0);

  // armed keeps pix_ready low until the first clock edge after reset release.
  assign pix_ready_int = armed && ((state == ST_IDLE) || (bit0_end && !last_flag));
  assign pix.pix_ready = pix_ready_int;
  assign xfer          = pix.pix_valid && pix_ready_int;

  assign busy      = (state != ST_IDLE);
  assign ws_data_n = ~ws_data;

  always_comb begin
    state_d      = state;
    cyc_d        = cyc;
    bit_idx_d    = bit_idx;
    shreg_d      = shreg;
    last_flag_d  = last_flag;
    latch_cnt_d  = latch_cnt;
    frame_done_d = 1'b0;

    case (state)
      ST_IDLE: ;
      ST_SHIFT: begin
        if (cyc == CYC_LAST) begin
          cyc_d = '0;
          if (bit_idx == 5'd0) begin
            if (!xfer) begin
              state_d     = ST_LATCH;
              latch_cnt_d = '0;
            end
          end else begin
            bit_idx_d = bit_idx - 5'd1;
            shreg_d   = {shreg[22:0], 1'b0};
          end
        end else begin
          cyc_d = cyc + CW'(1);
        end
      end
      ST_LATCH: begin
        if (latch_cnt == LATCH_LAST) begin
          state_d      = ST_IDLE;
          latch_cnt_d  = '0;
          frame_done_d = 1'b1;
        end else begin
          latch_cnt_d = latch_cnt + LW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A transfer can only happen in IDLE or in the last cycle of bit 0, and in
    // both cases the new pixel's bit 23 starts on the very next cycle.
    if (xfer) begin
      state_d     = ST_SHIFT;
      shreg_d     = pix.pix_data;
      last_flag_d = pix.pix_last;
      bit_idx_d   = 5'd23;
      cyc_d       = '0;
    end

    // ws_data is computed from the next state so the flop output lines up
    // with the cycle it describes.
    th_d      = shreg_d[23] ? T1H_V : T0H_V;
    ws_data_d = (state_d == ST_SHIFT) && (cyc_d < th_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cyc        <= '0;
      bit_idx    <= 5'd0;
      shreg      <= 24'd0;
      last_flag  <= 1'b0;
      latch_cnt  <= '0;
      frame_done <= 1'b0;
      ws_data    <= 1'b0;
      armed      <= 1'b0;
    end else begin
      state      <= state_d;
      cyc        <= cyc_d;
      bit_idx    <= bit_idx_d;
      shreg      <= shreg_d;
      last_flag  <= last_flag_d;
      latch_cnt  <= latch_cnt_d;
      frame_done <= frame_done_d;
      ws_data    <= ws_data_d;
      armed      <= 1'b1;
    end
  end

endmodule
